// File: rtl/bus_seq_ctrl.sv
// Micro-sequencer for the single shared datapath bus: fetch, decode and execute
// of ALU / LW / SW / JMP / HALT, with bounded memory-wait states.
//
// state | meaning
// S_RST | reset, no strobes
// F0    | PC -> MAR, start read, Z <= PC + 4
// F1    | Z -> PC
// F2    | wait for instruction word, MDR <= mem
// F3    | MDR -> IR
// DEC   | capture opcode, dispatch
// A0    | rs -> Y
// A1    | Z <= Y op rt
// A2    | Z -> rd
// L0    | rs -> Y
// L1    | Z <= Y + offset
// L2    | Z -> MAR (read request for LW)
// L3    | wait for load data, MDR <= mem
// L4    | MDR -> rt
// S3    | rt -> MDR
// S4    | wait for write accept
// J0    | offset -> PC
// HLT   | stopped until reset
module bus_seq_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_op,
  input  logic       mem_ready,
  output logic       pc_out,
  output logic       pc_in,
  output logic       mar_in,
  output logic       mdr_in,
  output logic       mdr_from_mem,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       ir_off_out,
  output logic       y_in,
  output logic       z_in,
  output logic       z_out,
  output logic       gpr_out,
  output logic       gpr_in,
  output logic [1:0] gpr_sel,
  output logic [1:0] alu_op,
  output logic       alu_b4,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       err
);

  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2,
    S_L0, S_L1, S_L2, S_L3, S_L4,
    S_S3, S_S4, S_J0, S_HLT
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
  localparam logic [3:0] OP_LW     = 4'd4;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_JMP    = 4'd6;
  localparam logic [3:0] OP_HALT   = 4'd7;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic [3:0] wait_cnt;
  logic       wait_st;
  logic       timeout;

  assign wait_st = (state == S_F2) || (state == S_L3) || (state == S_S4);
  // Timeout fires on the WAIT_MAX-th not-ready cycle; a ready in that cycle still wins.
  assign timeout = wait_st && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 op_q <= 4'd0;
    else if (state == S_DEC) op_q <= ir_op;
  end

  // Wait states never follow each other, so clearing outside them clears on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wait_cnt <= 4'd0;
    else if (!wait_st)  wait_cnt <= 4'd0;
    else if (!mem_ready) wait_cnt <= wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_F0;
      S_F0:  state_nxt = S_F1;
      S_F1:  state_nxt = S_F2;
      S_F2: begin
        if (mem_ready)    state_nxt = S_F3;
        else if (timeout) state_nxt = S_HLT;
      end
      S_F3:  state_nxt = S_DEC;
      S_DEC: begin
        if (ir_op[3])                              state_nxt = S_F0;
        else if (ir_op == OP_LW || ir_op == OP_SW) state_nxt = S_L0;
        else if (ir_op == OP_JMP)                  state_nxt = S_J0;
        else if (ir_op == OP_HALT)                 state_nxt = S_HLT;
        else                                       state_nxt = S_A0;
      end
      S_A0:  state_nxt = S_A1;
      S_A1:  state_nxt = S_A2;
      S_A2:  state_nxt = S_F0;
      S_L0:  state_nxt = S_L1;
      S_L1:  state_nxt = S_L2;
      S_L2:  state_nxt = (op_q == OP_SW) ? S_S3 : S_L3;
      S_L3: begin
        if (mem_ready)    state_nxt = S_L4;
        else if (timeout) state_nxt = S_HLT;
      end
      S_L4:  state_nxt = S_F0;
      S_S3:  state_nxt = S_S4;
      S_S4: begin
        if (mem_ready)    state_nxt = S_F0;
        else if (timeout) state_nxt = S_HLT;
      end
      S_J0:  state_nxt = S_F0;
      S_HLT: state_nxt = S_HLT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    pc_out       = 1'b0;
    pc_in        = 1'b0;
    mar_in       = 1'b0;
    mdr_in       = 1'b0;
    mdr_from_mem = 1'b0;
    mdr_out      = 1'b0;
    ir_in        = 1'b0;
    ir_off_out   = 1'b0;
    y_in         = 1'b0;
    z_in         = 1'b0;
    z_out        = 1'b0;
    gpr_out      = 1'b0;
    gpr_in       = 1'b0;
    gpr_sel      = 2'd0;
    alu_op       = 2'd0;
    alu_b4       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    halted       = 1'b0;
    case (state)
      S_F0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        mem_rd = 1'b1;
        alu_b4 = 1'b1;
        z_in   = 1'b1;
      end
      S_F1: begin
        z_out = 1'b1;
        pc_in = 1'b1;
      end
      S_F2, S_L3: begin
        mem_rd       = 1'b1;
        mdr_in       = mem_ready;
        mdr_from_mem = mem_ready;
      end
      S_F3: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_A0, S_L0: begin
        gpr_out = 1'b1;
        y_in    = 1'b1;
      end
      S_A1: begin
        gpr_out = 1'b1;
        gpr_sel = 2'd1;
        alu_op  = op_q[1:0];
        z_in    = 1'b1;
      end
      S_A2: begin
        z_out   = 1'b1;
        gpr_in  = 1'b1;
        gpr_sel = 2'd2;
      end
      S_L1: begin
        ir_off_out = 1'b1;
        z_in       = 1'b1;
      end
      S_L2: begin
        z_out  = 1'b1;
        mar_in = 1'b1;
        mem_rd = (op_q == OP_LW);
      end
      S_L4: begin
        mdr_out = 1'b1;
        gpr_in  = 1'b1;
        gpr_sel = 2'd1;
      end
      S_S3: begin
        gpr_out = 1'b1;
        gpr_sel = 2'd1;
        mdr_in  = 1'b1;
      end
      S_S4: mem_wr = 1'b1;
      S_J0: begin
        ir_off_out = 1'b1;
        pc_in      = 1'b1;
      end
      S_HLT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Bench for bus_seq_ctrl: per-instruction expected strobe traces built from the
// instruction-level micro-program, compared cycle by cycle under random mem_ready stalls.
module tb_bus_seq_ctrl;
  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir_op = 4'd0;
  logic       mem_ready = 1'b0;
  logic pc_out, pc_in, mar_in, mdr_in, mdr_from_mem, mdr_out, ir_in, ir_off_out;
  logic y_in, z_in, z_out, gpr_out, gpr_in, alu_b4, mem_rd, mem_wr, halted, err;
  logic [1:0] gpr_sel, alu_op;

  bus_seq_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .mem_ready(mem_ready),
    .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_from_mem(mdr_from_mem), .mdr_out(mdr_out), .ir_in(ir_in),
    .ir_off_out(ir_off_out), .y_in(y_in), .z_in(z_in), .z_out(z_out),
    .gpr_out(gpr_out), .gpr_in(gpr_in), .gpr_sel(gpr_sel), .alu_op(alu_op),
    .alu_b4(alu_b4), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_out, pc_in, mar_in, mdr_in, mdr_from_mem, mdr_out, ir_in, ir_off_out;
    logic       y_in, z_in, z_out, gpr_out, gpr_in;
    logic [1:0] gpr_sel, alu_op;
    logic       alu_b4, mem_rd, mem_wr, halted, err;
  } ov_t;

  int  n_checks = 0;
  int  n_fail = 0;
  ov_t exp_q[$];
  ov_t obs_q[$];
  bit  rdy_q[$];
  bit  model_err;
  int  dec_idx;

  function automatic ov_t sample();
    ov_t v;
    v.pc_out = pc_out; v.pc_in = pc_in; v.mar_in = mar_in; v.mdr_in = mdr_in;
    v.mdr_from_mem = mdr_from_mem; v.mdr_out = mdr_out; v.ir_in = ir_in;
    v.ir_off_out = ir_off_out; v.y_in = y_in; v.z_in = z_in; v.z_out = z_out;
    v.gpr_out = gpr_out; v.gpr_in = gpr_in; v.gpr_sel = gpr_sel; v.alu_op = alu_op;
    v.alu_b4 = alu_b4; v.mem_rd = mem_rd; v.mem_wr = mem_wr; v.halted = halted;
    v.err = err;
    return v;
  endfunction

  function automatic bit rb();
    return 1'($urandom & 1);
  endfunction

  // Bus exclusivity in every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ($countones({pc_out, mdr_out, ir_off_out, z_out, gpr_out}) > 1) begin
        n_fail++;
        $display("FAIL bus_exclusive t=%0t drivers=%b allowed=at most one", $time,
                 {pc_out, mdr_out, ir_off_out, z_out, gpr_out});
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push(input ov_t v, input bit r);
    v.err = model_err;
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  task automatic push_halted(input int n);
    ov_t v;
    v = '0;
    v.halted = 1'b1;
    for (int i = 0; i < n; i++) push(v, rb());
  endtask

  // A memory wait: 'stall' not-ready cycles then one ready cycle, or a timeout.
  task automatic push_wait(input ov_t held, input bit with_mdr, input int stall, output bit to);
    ov_t v;
    if (stall >= WAIT_MAX) begin
      for (int i = 0; i < WAIT_MAX; i++) push(held, 1'b0);
      model_err = 1'b1;
      push_halted(1);
      to = 1'b1;
    end else begin
      for (int i = 0; i < stall; i++) push(held, 1'b0);
      v = held;
      if (with_mdr) begin
        v.mdr_in = 1'b1;
        v.mdr_from_mem = 1'b1;
      end
      push(v, 1'b1);
      to = 1'b0;
    end
  endtask

  task automatic build(input logic [3:0] op, input int sf, input int sm);
    ov_t v;
    bit  to;
    exp_q.delete();
    rdy_q.delete();
    dec_idx = 1000;
    v = '0; v.pc_out = 1; v.mar_in = 1; v.mem_rd = 1; v.alu_b4 = 1; v.z_in = 1; push(v, rb());
    v = '0; v.z_out = 1; v.pc_in = 1; push(v, rb());
    v = '0; v.mem_rd = 1; push_wait(v, 1'b1, sf, to);
    if (to) return;
    v = '0; v.mdr_out = 1; v.ir_in = 1; push(v, rb());
    dec_idx = exp_q.size();
    v = '0; push(v, rb());
    if (op <= 4'd3) begin
      v = '0; v.gpr_out = 1; v.y_in = 1; push(v, rb());
      v = '0; v.gpr_out = 1; v.gpr_sel = 2'd1; v.alu_op = op[1:0]; v.z_in = 1; push(v, rb());
      v = '0; v.z_out = 1; v.gpr_in = 1; v.gpr_sel = 2'd2; push(v, rb());
    end else if (op == 4'd4 || op == 4'd5) begin
      v = '0; v.gpr_out = 1; v.y_in = 1; push(v, rb());
      v = '0; v.ir_off_out = 1; v.z_in = 1; push(v, rb());
      v = '0; v.z_out = 1; v.mar_in = 1; v.mem_rd = (op == 4'd4); push(v, rb());
      if (op == 4'd4) begin
        v = '0; v.mem_rd = 1; push_wait(v, 1'b1, sm, to);
        if (to) return;
        v = '0; v.mdr_out = 1; v.gpr_in = 1; v.gpr_sel = 2'd1; push(v, rb());
      end else begin
        v = '0; v.gpr_out = 1; v.gpr_sel = 2'd1; v.mdr_in = 1; push(v, rb());
        v = '0; v.mem_wr = 1; push_wait(v, 1'b0, sm, to);
      end
    end else if (op == 4'd6) begin
      v = '0; v.ir_off_out = 1; v.pc_in = 1; push(v, rb());
    end else if (op == 4'd7) begin
      push_halted(1);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    model_err = 1'b0;
    ir_op = 4'd0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts with the DUT in F0; ir_op may be scrambled after DEC.
  task automatic run_seq(input logic [3:0] op, input bit scramble, input int ncyc);
    obs_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      ir_op = (scramble && i > dec_idx) ? 4'($urandom) : op;
      mem_ready = rdy_q[i];
      @(negedge clk);
      obs_q.push_back(sample());
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ov_t zero;
    zero = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sample() !== zero) begin
      n_fail++; $display("FAIL reset_held got %h expected %h", sample(), zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sample() !== zero) begin
      n_fail++; $display("FAIL s_rst_idle got %h expected %h", sample(), zero);
    end
    @(posedge clk); #1;
    build(4'd0, 0, 0);
    run_seq(4'd0, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_add cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (pc_out !== 1'b1 || mem_rd !== 1'b1 || gpr_in !== 1'b0) begin
      n_fail++; $display("FAIL add_back_to_f0 got pc_out=%b mem_rd=%b expected 1 1", pc_out, mem_rd);
    end
  endtask

  task automatic test_alu();
    logic [3:0] ops[4] = '{4'd1, 4'd3, 4'd2, 4'd0};
    do_reset();
    foreach (ops[k]) begin
      build(ops[k], 0, 0);
      run_seq(ops[k], 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL alu op%0d cycle %0d got %h expected %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_lw_waits();
    do_reset();
    build(4'd4, 3, 2);
    run_seq(4'd4, 1'b0, exp_q.size());
    n_checks++;
    if (obs_q.size() != 15) begin
      n_fail++; $display("FAIL lw_length got %0d expected 15", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lw_wait cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sw();
    int stalls[2] = '{0, 2};
    do_reset();
    foreach (stalls[k]) begin
      build(4'd5, 0, stalls[k]);
      run_seq(4'd5, 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL sw stall%0d cycle %0d got %h expected %h", stalls[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] ops[4] = '{4'd0, 4'd4, 4'd5, 4'd0};
    int sfs[4] = '{15, 0, 0, 14};
    int sms[4] = '{0, 15, 15, 0};
    foreach (ops[k]) begin
      do_reset();
      build(ops[k], sfs[k], sms[k]);
      if (model_err) push_halted(4);
      run_seq(ops[k], 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL timeout case%0d cycle %0d got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared got err=%b halted=%b expected 0 0", err, halted);
    end
  endtask

  task automatic test_halt_illegal();
    do_reset();
    build(4'd7, 0, 0);
    push_halted(3);
    run_seq(4'd7, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL halt cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
    build(4'd9, 0, 0);
    run_seq(4'd9, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL illegal cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (pc_out !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL illegal_to_f0 got pc_out=%b halted=%b expected 1 0", pc_out, halted);
    end
  endtask

  task automatic test_capture();
    logic [3:0] ops[4] = '{4'd1, 4'd3, 4'd4, 4'd5};
    do_reset();
    foreach (ops[k]) begin
      build(ops[k], 1, 1);
      run_seq(ops[k], 1'b1, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL capture op%0d cycle %0d got %h expected %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ov_t zero;
    zero = '0;
    do_reset();
    build(4'd4, 0, 10);
    run_seq(4'd4, 1'b0, 11);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL async_pre cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL async_in_l3 got mem_rd=%b expected 1", mem_rd);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (sample() !== zero) begin
      n_fail++; $display("FAIL async_reset got %h expected %h", sample(), zero);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    int sf, sm;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      sf = ($urandom_range(0, 24) == 0) ? 15 : (($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3));
      sm = ($urandom_range(0, 24) == 0) ? 15 : (($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3));
      build(op, sf, sm);
      if (exp_q[exp_q.size()-1].halted) push_halted(2);
      run_seq(op, rb(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random n%0d op%0d cycle %0d got %h expected %h", n, op, i, obs_q[i], exp_q[i]);
        end
      end
      if (exp_q[exp_q.size()-1].halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_waits();
    test_sw();
    test_timeout();
    test_halt_illegal();
    test_capture();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_seq_ctrl.md
Name: bus_seq_ctrl

Overview:
Multi-cycle micro-sequencer that drives the single shared tri-state datapath bus. It generates every register's bus-drive (*_out) and bus-latch (*_in) strobes, plus the ALU and memory controls, state by state. It is the initiator side of the in/out strobe protocol that the bus registers (PC, MAR, MDR, IR, Y, Z, GPR file) obey, and it guarantees exactly zero or one bus driver per cycle. It sits beside the datapath and reads the opcode from IR.

Parameters:
WAIT_MAX, 15, maximum cycles spent in any memory-wait state before abort (4-bit counter range, 1..15).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
ir_op  in  4  opcode field of IR; valid from the DEC state onward
mem_ready  in  1  memory handshake: read data valid / write accepted
pc_out, pc_in  out  1  PC drive bus / latch from bus
mar_in  out  1  MAR latch from bus
mdr_in  out  1  MDR latch; source selected by mdr_from_mem
mdr_from_mem  out  1  1: MDR loads memory data; 0: MDR loads bus
mdr_out  out  1  MDR drive bus
ir_in  out  1  IR latch from bus
ir_off_out  out  1  IR sign-extended offset drives bus
y_in  out  1  Y latch from bus
z_in, z_out  out  1  Z latch ALU result / Z drive bus
gpr_out, gpr_in  out  1  register-file drive / latch
gpr_sel  out  2  0=rs, 1=rt, 2=rd
alu_op  out  2  0=ADD, 1=SUB, 2=AND, 3=OR
alu_b4  out  1  ALU B operand = constant 4 instead of bus
mem_rd, mem_wr  out  1  memory read / write request
halted  out  1  sequencer stopped
err  out  1  memory timeout occurred (sticky until rst)

Behaviour:
- Moore decode from the state register, except the mdr_in/mdr_from_mem and exit behaviour in wait states, which are qualified by mem_ready in the same cycle.
- Reset (async, any time, including mid-instruction or mid-wait): state=S_RST and all outputs 0. S_RST asserts nothing and goes to F0 on the first clock after rst falls.
- Unlisted outputs are 0 in every state. alu_op defaults to 0.
- F0: pc_out, mar_in, mem_rd, alu_b4, z_in (ADD). -> F1
- F1: z_out, pc_in. -> F2
- F2 (wait): mem_rd held. If mem_ready=1: mdr_in, mdr_from_mem, -> F3. Otherwise stay.
- F3: mdr_out, ir_in. -> DEC
- DEC: no strobes. Dispatch on ir_op: 0-3 -> A0; 4 (LW) -> L0; 5 (SW) -> L0; 6 (JMP) -> J0; 7 (HALT) -> HLT; 8-15 (illegal) -> F0 (treated as NOP).
- A0: gpr_out sel=0, y_in. -> A1
- A1: gpr_out sel=1, alu_op=ir_op[1:0], z_in. -> A2
- A2: z_out, gpr_in sel=2. -> F0
- L0: gpr_out sel=0, y_in. -> L1
- L1: ir_off_out, alu ADD, z_in. -> L2
- L2: z_out, mar_in, and mem_rd only for LW. LW -> L3; SW -> S3.
- L3 (wait): mem_rd held. If mem_ready: mdr_in, mdr_from_mem, -> L4.
- L4: mdr_out, gpr_in sel=1. -> F0
- S3: gpr_out sel=1, mdr_in, mdr_from_mem=0. -> S4
- S4 (wait): mem_wr held. If mem_ready -> F0.
- J0: ir_off_out, pc_in. -> F0
- HLT: halted=1, all strobes 0. Stays until rst.
- ir_op is captured into an internal register in DEC. Later execute states use the captured copy, so an IR change after DEC has no effect.
- Wait counter: cleared on entry to each wait state (F2, L3, S4) and incremented every cycle mem_ready=0.
  - If the counter reaches WAIT_MAX with mem_ready still 0: go to HLT, set err=1, drop mem_rd/mem_wr.
  - mem_ready=1 in the same cycle the limit is reached wins (normal exit).
- mem_ready outside the wait states is ignored.
- Invariant: at most one of {pc_out, mdr_out, ir_off_out, z_out, gpr_out} is high in any cycle.
- Cycle counts with mem_ready tied 1, measured F0 to next F0: ALU = 8, LW = 10, SW = 10, JMP = 6, illegal = 5.

Test Plan:
- rst pulse, mem_ready=1, ir_op=0 (ADD) -> all outputs 0 during rst and in S_RST; F0 strobes (pc_out, mar_in, mem_rd, alu_b4, z_in) on the 2nd clock; gpr_in with sel=2 in cycle 8; back to F0 in cycle 9.
- ir_op=1 (SUB), then ir_op=3 (OR) -> alu_op=1 and alu_op=3 in A1; y_in only in A0.
- LW with mem_ready low for 3 cycles in F2 and 2 cycles in L3 -> mem_rd held throughout; mdr_in+mdr_from_mem pulse exactly once per wait, in the mem_ready cycle; total 15 cycles.
- SW, mem_ready=1 -> S3 has gpr_out, sel=1, mdr_in, mdr_from_mem=0; mem_wr high one cycle; mem_rd never high in L2.
- mem_ready stuck 0 in F2 with WAIT_MAX=15 -> HLT after 15 wait cycles; err=1, halted=1; stays halted until rst, then err clears.
- ir_op=7 -> halted=1 after DEC. ir_op=9 -> F0 after DEC with no strobes. rst asserted mid-L3 -> outputs 0 immediately (asynchronous). Bus-exclusivity assertion holds in every cycle of all tests.
